// File: rtl/rs_pkg.sv
// Shared definitions for the RS(204,188) decoder datapath: code geometry,
// write-address width and the stage FSM encoding used by input and output stages.
package rs_pkg;

    localparam int N      = 204;  // codeword length in bytes
    localparam int K      = 188;  // message length in bytes
    localparam int ADDR_W = 8;    // ping-pong memory address width

    typedef logic [0:0] state_t;

    localparam state_t IDLE = 1'b0;
    localparam state_t FILL = 1'b1;

endpackage

// File: rtl/in_stage.sv
// Input stage of the RS(204,188) decoder. Takes one received byte per CE slot,
// writes each codeword into the current bank of the ping-pong memory and flips
// the bank with a block_done pulse once all N bytes of a codeword are stored.
module in_stage #(
    parameter int N      = rs_pkg::N,
    parameter int ADDR_W = rs_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CE,
    input  logic              Valid_in,
    input  logic              Start,
    input  logic [7:0]        In_byte,
    input  logic              clr_err,
    output logic              WE,
    output logic [ADDR_W-1:0] WrAdd,
    output logic [7:0]        Wr_byte,
    output logic              bank,
    output logic              block_done,
    output logic              busy,
    output logic              overrun
);
    import rs_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

    state_t            state_reg;
    logic [ADDR_W-1:0] count_reg;
    logic              last_reg;   // final byte of a block was written this cycle

    logic              accept;
    logic              in_fill;
    logic              do_write;
    logic              do_final;
    logic              do_abort;
    logic [ADDR_W-1:0] wr_addr;

    // A Start byte always lands at address 0, whether it opens a block from
    // IDLE or aborts an unfinished one; otherwise the counter is the address.
    assign accept   = CE & Valid_in;
    assign in_fill  = (state_reg == FILL);
    assign do_write = accept & (Start | in_fill);
    assign do_final = accept & ~Start & in_fill & (count_reg == LAST_ADDR);
    assign do_abort = accept & Start & in_fill;
    assign wr_addr  = Start ? '0 : count_reg;

    // busy is a direct view of the state register, so it is still registered.
    assign busy = in_fill;

    // FSM and byte counter: advance only on accepted bytes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
        end else if (accept) begin
            if (Start) begin
                state_reg <= FILL;
                count_reg <= ADDR_W'(1);
            end else if (in_fill) begin
                if (count_reg == LAST_ADDR) begin
                    state_reg <= IDLE;
                    count_reg <= '0;
                end else begin
                    count_reg <= count_reg + ADDR_W'(1);
                end
            end
        end
    end

    // Output registers: memory write port, block completion, bank flip and overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            WE         <= 1'b0;
            WrAdd      <= '0;
            Wr_byte    <= '0;
            last_reg   <= 1'b0;
            block_done <= 1'b0;
            bank       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            WE <= do_write;
            if (do_write) begin
                WrAdd   <= wr_addr;
                Wr_byte <= In_byte;
            end
            // block_done and the bank flip trail the final write by one cycle
            last_reg   <= do_final;
            block_done <= last_reg;
            if (last_reg) begin
                bank <= ~bank;
            end
            // a simultaneous abort and clear leaves the error set
            if (do_abort) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_in_stage.sv
// Scoreboard bench for in_stage: the driver feeds CE slots and a codeword-level
// model predicts writes and block completions into queues; a monitor pops and
// compares whenever the DUT shows WE or block_done.
module tb_in_stage;

    localparam int N = 204;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       CE = 1'b0;
    logic       Valid_in = 1'b0;
    logic       Start = 1'b0;
    logic [7:0] In_byte = 8'd0;
    logic       clr_err = 1'b0;
    logic       WE;
    logic [7:0] WrAdd;
    logic [7:0] Wr_byte;
    logic       bank;
    logic       block_done;
    logic       busy;
    logic       overrun;

    in_stage dut (
        .clk(clk), .reset(reset), .CE(CE), .Valid_in(Valid_in), .Start(Start),
        .In_byte(In_byte), .clr_err(clr_err), .WE(WE), .WrAdd(WrAdd),
        .Wr_byte(Wr_byte), .bank(bank), .block_done(block_done), .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // expected memory writes {addr, data} and expected bank value after each block_done
    int wq_addr[$];
    int wq_data[$];
    int dq_bank[$];

    // reference model of the codeword being assembled
    bit m_in_block = 0;
    int m_index    = 0;
    int m_bank     = 0;
    bit m_over     = 0;
    int writes_seen = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every write and completion the DUT shows must match the scoreboard.
    bit prev_we = 0;
    int prev_addr = 0;
    always @(negedge clk) begin
        if (reset) begin
            prev_we = 0;
        end else begin
            if (WE) begin
                writes_seen++;
                if (wq_addr.size() == 0) begin
                    chk("unexpected_we_addr", int'(WrAdd), -1);
                end else begin
                    chk("wr_addr", int'(WrAdd), wq_addr.pop_front());
                    chk("wr_byte", int'(Wr_byte), wq_data.pop_front());
                end
            end
            if (block_done) begin
                chk("done_after_last_we", (prev_we && prev_addr == N - 1) ? 1 : 0, 1);
                if (dq_bank.size() == 0) begin
                    chk("unexpected_block_done", 1, 0);
                end else begin
                    chk("bank_at_done", int'(bank), dq_bank.pop_front());
                end
            end
            prev_we   = WE;
            prev_addr = int'(WrAdd);
        end
    end

    // One CE slot of 8 clocks; the model is updated from the codeword rules and
    // the slow status outputs are compared once the slot has settled.
    task automatic send(input bit st, input bit v, input logic [7:0] b, input bit clr);
        bit set_ov;
        @(negedge clk);
        CE = 1'b1; Valid_in = v; Start = st; In_byte = b; clr_err = clr;
        set_ov = 0;
        if (v) begin
            if (st) begin
                if (m_in_block) begin
                    m_over = 1;
                    set_ov = 1;
                end
                wq_addr.push_back(0);
                wq_data.push_back(int'(b));
                m_in_block = 1;
                m_index = 1;
            end else if (m_in_block) begin
                wq_addr.push_back(m_index);
                wq_data.push_back(int'(b));
                if (m_index == N - 1) begin
                    m_in_block = 0;
                    m_index = 0;
                    m_bank = 1 - m_bank;
                    dq_bank.push_back(m_bank);
                end else begin
                    m_index++;
                end
            end
        end
        if (clr && !set_ov) m_over = 0;
        @(negedge clk);
        CE = 1'b0; Valid_in = 1'b0; Start = 1'b0; clr_err = 1'b0;
        repeat (6) @(negedge clk);
        chk("busy", int'(busy), int'(m_in_block));
        chk("overrun", int'(overrun), int'(m_over));
        chk("bank", int'(bank), m_bank);
    endtask

    task automatic data_byte(input bit st);
        send(st, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_we"}, int'(WE), 0);
        chk({tag, "_wradd"}, int'(WrAdd), 0);
        chk({tag, "_wr_byte"}, int'(Wr_byte), 0);
        chk({tag, "_bank"}, int'(bank), 0);
        chk({tag, "_block_done"}, int'(block_done), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_overrun"}, int'(overrun), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start_writes;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // idle noise: non-Start accepts are discarded
        for (int i = 0; i < 4; i++) data_byte(1'b0);

        // nominal block, In_byte = index
        for (int i = 0; i < N; i++) send(i == 0, 1'b1, 8'(i), 1'b0);
        chk("block1_writes", writes_seen, N);

        // contiguous second block with two invalid slots before byte 10
        for (int i = 0; i < N; i++) begin
            if (i == 10) begin
                send(1'b0, 1'b0, 8'hAA, 1'b0);
                send(1'b0, 1'b0, 8'h55, 1'b0);
            end
            data_byte(i == 0);
        end
        chk("block2_writes", writes_seen, 2 * N);

        // overrun: Start at position 100, then a full block from there
        for (int i = 0; i < 100; i++) data_byte(i == 0);
        start_writes = writes_seen;
        data_byte(1'b1);
        for (int i = 1; i < N; i++) data_byte(1'b0);
        chk("overrun_block_writes", writes_seen - start_writes, N);

        // clear coincident with a mid-block Start keeps overrun, lone clear drops it
        for (int i = 0; i < 30; i++) data_byte(i == 0);
        send(1'b1, 1'b1, 8'h3C, 1'b1);
        send(1'b0, 1'b0, 8'h00, 1'b1);

        // asynchronous reset at byte 50 of a block
        for (int i = 1; i < 50; i++) data_byte(1'b0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_all_zero("midreset");
        m_in_block = 0; m_index = 0; m_bank = 0; m_over = 0;
        @(negedge clk);
        reset = 1'b0;
        data_byte(1'b0);
        for (int i = 0; i < N; i++) data_byte(i == 0);

        // randomized traffic: sparse Starts, invalid slots and clears
        for (int i = 0; i < 900; i++) begin
            send($urandom_range(0, 299) == 0, $urandom_range(0, 7) != 0,
                 8'($urandom_range(0, 255)), $urandom_range(0, 39) == 0);
        end

        repeat (10) @(negedge clk);
        chk("writes_drained", wq_addr.size(), 0);
        chk("done_drained", dq_bank.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
